// File: rtl/bus_pkg.sv
// Shared definitions for the data bus and its receive queue.
package bus_pkg;

  // Width of one word on the shared tri-state data bus.
  localparam int BUS_W = 32;

  // Entries in the bus receive queue unless a parent overrides it.
  localparam int FIFO_DEPTH = 4;

  typedef logic [BUS_W-1:0] bus_word_t;

endpackage : bus_pkg

// File: rtl/bus_rx_mem.sv
// Storage array for the bus receive queue: one synchronous write port and
// one combinational read port. The contents are deliberately left unreset.
module bus_rx_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the incoming bus word into the selected slot.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : bus_rx_mem

// File: rtl/bus_rx_fifo.sv
// Receive queue for the shared 32-bit data bus. Every cycle the bus driver
// enable is high, the bus word is captured into a small FIFO. The consumer
// drains it over a valid/ready handshake. A word arriving at a full queue is
// dropped and latched into the sticky overflow flag.
// Optional build macro: BUS_RX_DROP_CNT_EN adds a saturating 16-bit drop_cnt
// output that counts dropped words and is cleared together with overflow.
module bus_rx_fifo
  import bus_pkg::*;
#(
  parameter  int DATA_W = BUS_W,
  parameter  int DEPTH  = FIFO_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_bus,
  input  logic              bus_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              full,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [PTR_W:0]    level
`ifdef BUS_RX_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [PTR_W:0]    wrPtr_q, wrPtr_d;
  logic [PTR_W:0]    rdPtr_q, rdPtr_d;
  logic              ovf_q, ovf_d;
  logic              isEmpty, isFull;
  logic              doPush, doPop, dropEv;
  logic [DATA_W-1:0] memRdata;

  assign isEmpty = (wrPtr_q == rdPtr_q);
  assign isFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                   (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);

  // A pop frees a slot in the same edge, so a full queue still accepts a push
  // when the consumer is taking the head word.
  assign doPop  = !isEmpty && out_ready;
  assign doPush = bus_en && (!isFull || doPop);
  assign dropEv = bus_en && isFull && !doPop;

  // Next-state for the pointers and the sticky overflow flag; a new drop beats a clear.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    ovf_d   = ovf_q;
    if (doPush) begin
      wrPtr_d = wrPtr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (doPop) begin
      rdPtr_d = rdPtr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (dropEv) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Pointer and flag registers; reset empties the queue immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      ovf_q   <= ovf_d;
    end
  end

  bus_rx_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (doPush),
    .waddr_i (wrPtr_q[PTR_W-1:0]),
    .wdata_i (data_bus),
    .raddr_i (rdPtr_q[PTR_W-1:0]),
    .rdata_o (memRdata)
  );

  // The storage is never reset, so the head word is forced to zero while empty.
  assign out_data  = isEmpty ? '0 : memRdata;
  assign out_valid = !isEmpty;
  assign full      = isFull;
  assign overflow  = ovf_q;
  assign level     = wrPtr_q - rdPtr_q;

`ifdef BUS_RX_DROP_CNT_EN
  logic [15:0] dropCnt_q, dropCnt_d;

  // Saturating drop counter; a drop coinciding with a clear restarts the count at one.
  always_comb begin
    dropCnt_d = dropCnt_q;
    if (dropEv) begin
      if (clr_ovf) begin
        dropCnt_d = 16'd1;
      end else if (dropCnt_q != 16'hFFFF) begin
        dropCnt_d = dropCnt_q + 16'd1;
      end
    end else if (clr_ovf) begin
      dropCnt_d = 16'd0;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dropCnt_q <= 16'd0;
    end else begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_cnt = dropCnt_q;
`endif

endmodule : bus_rx_fifo

// File: tb/tb_bus_rx_fifo.sv
// Directed bench for bus_rx_fifo with hand-computed expectations. The
// BUS_RX_DROP_CNT_EN macro also enables the drop counter checks.
module tb_bus_rx_fifo;

  localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

  logic        clk;
  logic        reset;
  logic [31:0] data_bus;
  logic        bus_en;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        full;
  logic        overflow;
  logic        clr_ovf;
  logic [2:0]  level;
`ifdef BUS_RX_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bus_rx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .data_bus  (data_bus),
    .bus_en    (bus_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .level     (level)
`ifdef BUS_RX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one bus word for a single cycle, then leave the bus undriven.
  task automatic pushWord(input logic [31:0] w);
    bus_en   = 1'b1;
    data_bus = w;
    cycle();
    bus_en   = 1'b0;
    data_bus = GARBAGE;
  endtask

  task automatic test_reset();
    bus_en    = 1'b0;
    data_bus  = GARBAGE;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    cycle();
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00000000", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); end
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
`ifdef BUS_RX_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_dropcnt: got %0d expected 0", drop_cnt); end
`endif
  endtask

  task automatic test_single_push();
    out_ready = 1'b0;
    pushWord(32'hAAAA_AAAA);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'hAAAA_AAAA) begin errors++; $display("[TB] FAIL single_data: got %h expected aaaaaaaa", out_data); end
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL single_level: got %0d expected 1", level); end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_pop_valid: got %b expected 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL single_pop_level: got %0d expected 0", level); end
  endtask

  task automatic test_fill_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) pushWord(32'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full: got %b expected 1", full); end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL fill_level: got %0d expected 4", level); end
    checks++; if (out_data !== 32'h1) begin errors++; $display("[TB] FAIL fill_head: got %h expected 00000001", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fill_ovf: got %b expected 0", overflow); end
    pushWord(32'h5);
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL drop_ovf: got %b expected 1", overflow); end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL drop_level: got %0d expected 4", level); end
    checks++; if (out_data !== 32'h1) begin errors++; $display("[TB] FAIL drop_head: got %h expected 00000001", out_data); end
`ifdef BUS_RX_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL drop_cnt1: got %0d expected 1", drop_cnt); end
`endif
    pushWord(32'h6);
`ifdef BUS_RX_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("[TB] FAIL drop_cnt2: got %0d expected 2", drop_cnt); end
`endif
    clr_ovf = 1'b1;
    pushWord(32'h7);
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL clr_vs_drop_ovf: got %b expected 1", overflow); end
`ifdef BUS_RX_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("[TB] FAIL clr_vs_drop_cnt: got %0d expected 1", drop_cnt); end
`endif
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf: got %b expected 0", overflow); end
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL clr_level: got %0d expected 4", level); end
`ifdef BUS_RX_DROP_CNT_EN
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("[TB] FAIL clr_cnt: got %0d expected 0", drop_cnt); end
`endif
  endtask

  task automatic test_full_push_pop();
    logic [31:0] drainExp [4];
    drainExp[0] = 32'h2;
    drainExp[1] = 32'h3;
    drainExp[2] = 32'h4;
    drainExp[3] = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    checks++; if (out_data !== 32'h1) begin errors++; $display("[TB] FAIL fpp_popped: got %h expected 00000001", out_data); end
    pushWord(32'hDEAD_BEEF);
    checks++; if (level !== 3'd4) begin errors++; $display("[TB] FAIL fpp_level: got %0d expected 4", level); end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL fpp_full: got %b expected 1", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp_ovf: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid%0d: got %b expected 1", i, out_valid); end
      checks++; if (out_data !== drainExp[i]) begin errors++; $display("[TB] FAIL drain_data%0d: got %h expected %h", i, out_data, drainExp[i]); end
      cycle();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %b expected 0", out_valid); end
    cycle();
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL empty_ready_level: got %0d expected 0", level); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL empty_ready_data: got %h expected 00000000", out_data); end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    logic [31:0] expq [$];
    int sent = 0;
    int got  = 0;
    bit pushNow, readyNow;
    for (int cyc = 0; cyc < 60 && got < 12; cyc++) begin
      pushNow  = (cyc % 2 == 0) && (sent < 12);
      readyNow = (cyc % 2 == 0);
      bus_en    = pushNow;
      data_bus  = pushNow ? (32'hC000_0100 + 32'(sent)) : GARBAGE;
      out_ready = readyNow;
      checks++; if (out_valid !== (expq.size() > 0)) begin errors++; $display("[TB] FAIL stream_valid c%0d: got %b expected %b", cyc, out_valid, expq.size() > 0); end
      if (readyNow && expq.size() > 0) begin
        checks++; if (out_data !== expq[0]) begin errors++; $display("[TB] FAIL stream_data w%0d: got %h expected %h", got, out_data, expq[0]); end
        void'(expq.pop_front());
        got++;
      end
      if (pushNow) begin
        expq.push_back(32'hC000_0100 + 32'(sent));
        sent++;
      end
      cycle();
      checks++; if (level !== 3'(expq.size())) begin errors++; $display("[TB] FAIL stream_level c%0d: got %0d expected %0d", cyc, level, expq.size()); end
    end
    bus_en    = 1'b0;
    data_bus  = GARBAGE;
    out_ready = 1'b0;
    checks++; if (got !== 12) begin errors++; $display("[TB] FAIL stream_count: got %0d expected 12", got); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL stream_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    pushWord(32'h11);
    pushWord(32'h22);
    pushWord(32'h33);
    checks++; if (level !== 3'd3) begin errors++; $display("[TB] FAIL ar_pre_level: got %0d expected 3", level); end
    #3 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_valid: got %b expected 0", out_valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("[TB] FAIL ar_level: got %0d expected 0", level); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL ar_data: got %h expected 00000000", out_data); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ar_ovf: got %b expected 0", overflow); end
    #2 reset = 1'b0;
    cycle();
    pushWord(32'h55);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ar_post_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 32'h55) begin errors++; $display("[TB] FAIL ar_post_data: got %h expected 00000055", out_data); end
    checks++; if (level !== 3'd1) begin errors++; $display("[TB] FAIL ar_post_level: got %0d expected 1", level); end
  endtask

  // Scenario sequence.
  initial begin
    reset     = 1'b1;
    bus_en    = 1'b0;
    data_bus  = GARBAGE;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    test_reset();
    test_single_push();
    test_fill_overflow();
    test_full_push_pop();
    test_streaming();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bus_rx_fifo

// File: doc/bus_rx_fifo.md
Name: bus_rx_fifo

Overview:
- Receiving end of the shared 32-bit tri-state data bus; the bus is driven by `conditional_buffer` instances gated by their enable `y`.
- Samples the bus on every clock edge where the driver's enable (`bus_en`) is high, and queues each word in a small FIFO.
- Presents queued words to a downstream consumer (register file or accumulator load path) over a valid/ready handshake.
- Flags words lost to a full queue.

Parameters:
- DATA_W, 32, bus word width.
- DEPTH, 4, number of FIFO entries; must be a power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer index width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- data_bus  input  DATA_W  shared tri-state bus; meaningful only while bus_en=1.
- bus_en  input  1  driver enable (same net as the driver's `y`); 1 = bus is driven this cycle.
- out_data  output  DATA_W  head-of-queue word.
- out_valid  output  1  queue non-empty.
- out_ready  input  1  consumer accepts head word this cycle.
- full  output  1  queue holds DEPTH words.
- overflow  output  1  sticky: a bus word was dropped.
- clr_ovf  input  1  synchronous clear of overflow.
- level  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset, asynchronous, active-high:
  - Pointers, level and overflow go to 0; out_valid=0; full=0; out_data=0.
  - Storage array contents are not reset.
- Push: occurs at the rising clk edge when bus_en=1.
  - data_bus is written at wr_ptr.
  - X/Z values on data_bus while bus_en=0 are never sampled and must not propagate anywhere.
- Pop: occurs at the rising edge when out_valid=1 and out_ready=1; rd_ptr advances.
- Latency:
  - A word pushed into an empty queue appears on out_data with out_valid=1 on the next cycle.
  - There is no combinational bus-to-output path.
- out_data is always mem[rd_ptr]. Its value while out_valid=0 is don't-care but must be stable, not X after reset; drive 0 when empty.
- Pointers are PTR_W+1 bits wide and wrap naturally:
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and index bits equal.
  - level = wr_ptr − rd_ptr, modulo 2^(PTR_W+1).
- Boundary conditions:
  - Full, push only: word dropped; overflow set to 1 next edge; pointers unchanged.
  - Full, push and pop in the same cycle: both accepted; level stays DEPTH; no overflow.
  - Empty, push and pop in the same cycle: the pop is ignored (out_valid=0); the push is accepted; level becomes 1.
  - Non-full, non-empty, simultaneous push and pop: level unchanged.
  - out_ready=1 while empty: no effect.
  - clr_ovf with a coinciding overflow event: the set wins; overflow remains 1.
- Reset asserted mid-stream: the queue empties immediately (asynchronous). Words in flight are lost and overflow is not raised.
- No state machine beyond the pointer/flag registers.

Optional Feature:
- Macro: BUS_RX_DROP_CNT_EN.
- With the macro defined:
  - Adds output drop_cnt [15:0], which counts dropped words.
  - drop_cnt saturates at 16'hFFFF, resets to 0, and is cleared by clr_ovf.
  - If clr_ovf and a drop coincide, drop_cnt becomes 1.
- Without the macro: the port and counter do not exist. Only the sticky overflow reports drops.

Decomposition:
- Shared package `bus_pkg` holds:
  - BUS_W=32.
  - typedef bus_word_t (logic [BUS_W-1:0]).
  - The default FIFO depth constant.
- Sub-module `bus_rx_mem`: DEPTH×DATA_W storage with one write port and a combinational read port; no reset.
- Pointer, flag and level logic stays in bus_rx_fifo.

Test Plan:
- Reset, then hold bus_en=0 while a `conditional_buffer` drives Z -> out_valid=0, level=0, out_data=32'h0, overflow=0.
- Single push of 32'hAAAAAAAA, out_ready=0 -> next cycle out_valid=1, out_data=32'hAAAAAAAA, level=1. Then out_ready=1 for one cycle -> out_valid=0, level=0.
- Push 32'h1, 32'h2, 32'h3, 32'h4 with out_ready=0 -> full=1, level=4.
  - Push 32'h5 -> overflow=1, level=4, word 5 is never output. With BUS_RX_DROP_CNT_EN, drop_cnt=1.
  - Pulse clr_ovf -> overflow=0.
- Full queue with simultaneous push of 32'hDEAD_BEEF and pop -> out_data pops 32'h1; level stays 4; overflow=0.
  - Drain the queue -> output order 2, 3, 4, DEADBEEF.
- Continuous streaming of 12 words with out_ready toggling 1/0 every cycle -> all 12 words are received in order, overflow=0, and pointers wrap correctly.
- Assert reset asynchronously (mid-cycle) while level=3 -> outputs clear immediately, before the next clk edge. After release, a new push of 32'h55 produces out_data=32'h55.
